// File: rtl/muntjac_pkg.sv
// Shared types and constants for the muntjac refill path.
package muntjac_pkg;

  localparam int RefillAddrLen  = 56;
  localparam int RefillLenWidth = 3;

  localparam logic RefillIdDcache = 1'b0;
  localparam logic RefillIdIcache = 1'b1;

  typedef struct packed {
    logic [RefillAddrLen-1:0]  addr;
    logic [RefillLenWidth-1:0] len;
  } refill_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } refill_arb_state_e;

endpackage

// File: rtl/muntjac_rr_arbiter.sv
// Combinational N-way round-robin pick. The search starts just after the
// previous winner and wraps, so the previous winner has lowest priority.
module muntjac_rr_arbiter #(
  parameter int N    = 2,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid,
  input  logic [IdxW-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  // walk candidates in priority order, keep the first valid one
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IdxW'((int'(last) + off) % N);
      if (!found && valid[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/muntjac_refill_arbiter.sv
// Shares one downstream refill port between the dcache (0) and icache (1).
// One read burst in flight at a time, round-robin between requesters, grant
// held until the last response beat.
// Optional: MUNTJAC_REFILL_ARB_PERF_EN adds saturating grant/wait counters.
//
//   state | meaning
//   IDLE  | no burst; accept the round-robin winner
//   REQ   | presenting latched request downstream
//   RESP  | routing response beats to the owner
module muntjac_refill_arbiter
  import muntjac_pkg::*;
#(
  parameter int PhysAddrLen = 56,
  parameter int DataWidth   = 64,
  parameter int LenWidth    = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [1:0][PhysAddrLen-1:0] req_addr_i,
  input  logic [1:0][LenWidth-1:0]    req_len_i,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [PhysAddrLen-1:0]      mem_req_addr_o,
  output logic [LenWidth-1:0]         mem_req_len_o,
  output logic                        mem_req_id_o,
  input  logic                        mem_resp_valid_i,
  output logic                        mem_resp_ready_o,
  input  logic [DataWidth-1:0]        mem_resp_data_i,
  input  logic                        mem_resp_last_i,
  output logic [1:0]                  resp_valid_o,
  input  logic [1:0]                  resp_ready_i,
  output logic [DataWidth-1:0]        resp_data_o,
  output logic                        busy_o,
  output logic                        err_o
`ifdef MUNTJAC_REFILL_ARB_PERF_EN
  ,
  output logic [1:0][31:0]            grant_cnt_o,
  output logic [31:0]                 wait_cnt_o
`endif
);

  refill_arb_state_e      state_q, state_d;
  logic                   last_q;
  logic [PhysAddrLen-1:0] addr_q;
  logic [LenWidth-1:0]    len_q;
  logic [LenWidth-1:0]    cnt_q;
  logic                   id_q;
  logic                   err_q;

  logic [1:0] win_gnt;
  logic       win_idx;
  logic       accept;
  logic       beat;

  muntjac_rr_arbiter #(.N(2)) u_rr (
    .valid (req_valid_i),
    .last  (last_q),
    .gnt   (win_gnt),
    .idx   (win_idx)
  );

  // next state and all handshake/routing outputs
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    req_ready_o      = '0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    resp_valid_o     = '0;
    resp_data_o      = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o = win_gnt;
          accept      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        resp_valid_o[id_q] = mem_resp_valid_i;
        mem_resp_ready_o   = resp_ready_i[id_q];
        resp_data_o        = mem_resp_data_i;
        if (mem_resp_valid_i && mem_resp_ready_o && mem_resp_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is only ever raised in RESP, so this is a RESP beat handshake
  assign beat = mem_resp_valid_i & mem_resp_ready_o;

  // state, latched request, beat counter and sticky length error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= RefillIdIcache;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= RefillIdDcache;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr_i[win_idx];
        len_q  <= req_len_i[win_idx];
        id_q   <= win_idx;
        last_q <= win_idx;
        cnt_q  <= '0;
      end
      if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        // last must coincide exactly with the beat numbered len
        if (mem_resp_last_i != (cnt_q == len_q)) err_q <= 1'b1;
      end
    end
  end

  assign mem_req_addr_o = addr_q;
  assign mem_req_len_o  = len_q;
  assign mem_req_id_o   = id_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;

`ifdef MUNTJAC_REFILL_ARB_PERF_EN
  logic [1:0][31:0] grant_cnt_q;
  logic [31:0]      wait_cnt_q;

  // saturating per-requester grant counts and stalled-request cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (req_ready_o[r] && (grant_cnt_q[r] != '1)) grant_cnt_q[r] <= grant_cnt_q[r] + 32'd1;
      end
      if ((|req_valid_i) && !(|req_ready_o) && (wait_cnt_q != '1)) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign wait_cnt_o  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_muntjac_refill_arbiter.sv
// Randomised scoreboard bench for muntjac_refill_arbiter.
module tb_muntjac_refill_arbiter;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [1:0][55:0]  req_addr_i;
  logic [1:0][2:0]   req_len_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [55:0]       mem_req_addr_o;
  logic [2:0]        mem_req_len_o;
  logic              mem_req_id_o;
  logic              mem_resp_valid_i;
  logic              mem_resp_ready_o;
  logic [63:0]       mem_resp_data_i;
  logic              mem_resp_last_i;
  logic [1:0]        resp_valid_o;
  logic [1:0]        resp_ready_i;
  logic [63:0]       resp_data_o;
  logic              busy_o;
  logic              err_o;
`ifdef MUNTJAC_REFILL_ARB_PERF_EN
  logic [1:0][31:0]  grant_cnt_o;
  logic [31:0]       wait_cnt_o;
`endif

  always #5 clk = ~clk;

  muntjac_refill_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_len_i        (req_len_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_len_o    (mem_req_len_o),
    .mem_req_id_o     (mem_req_id_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_last_i  (mem_resp_last_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_data_o      (resp_data_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
`ifdef MUNTJAC_REFILL_ARB_PERF_EN
    ,
    .grant_cnt_o      (grant_cnt_o),
    .wait_cnt_o       (wait_cnt_o)
`endif
  );

  typedef struct {
    logic        id;
    logic [55:0] addr;
    logic [2:0]  len;
  } mreq_t;

  typedef struct {
    logic        id;
    logic [63:0] data;
  } beat_t;

  mreq_t exp_req[$];
  beat_t exp_resp[$];

  int   n_vec = 0;
  int   n_bad = 0;
  bit   run   = 1'b0;
  bit   stop  = 1'b0;
  int   acc   = 0;      // transactions granted (requester side)
  int   done  = 0;      // transactions completed (fabric side)
  bit   just_acc = 1'b0;
  logic last_w;
  logic [1:0] pres = 2'b00;
  int   phase = 0;      // 0: awaiting downstream request, 1: delivering beats
  int   beat_idx = 0;
  int   grants_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // response consumers: random back-pressure on both caches
  initial begin
    resp_ready_i = 2'b00;
    forever begin
      @(negedge clk);
      resp_ready_i = {($urandom % 4) != 0, ($urandom % 4) != 0};
    end
  end

  // requesters plus round-robin reference: expected grant from pending set
  initial begin
    logic [1:0][55:0] p_addr;
    logic [1:0][2:0]  p_len;
    logic [1:0]       exp_rdy;
    logic             o, w;
    bit               inf;
    p_addr = '0;
    p_len  = '0;
    last_w = 1'b1;
    req_valid_i = 2'b00;
    req_addr_i  = '0;
    req_len_i   = '0;
    forever begin
      @(negedge clk);
      just_acc = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (!pres[r] && run && !stop && ($urandom % 3) == 0) begin
          pres[r]   = 1'b1;
          p_addr[r] = 56'({$urandom, $urandom});
          p_len[r]  = 3'($urandom);
        end
      end
      req_valid_i = pres;
      req_addr_i  = p_addr;
      req_len_i   = p_len;
      #1;
      if (rst_i) begin
        acc    = 0;
        last_w = 1'b1;
      end else begin
        inf = (acc != done);
        chk("busy", 64'(busy_o), 64'(inf));
        exp_rdy = 2'b00;
        if (!inf && pres != 2'b00) begin
          o = ~last_w;
          w = pres[o] ? o : last_w;
          exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        if (exp_rdy != 2'b00) begin
          exp_req.push_back('{id: w, addr: p_addr[w], len: p_len[w]});
          pres[w]  = 1'b0;
          acc++;
          last_w   = w;
          just_acc = 1'b1;
          grants_seen++;
        end
      end
    end
  end

  // memory fabric model: accepts requests, returns bursts, tracks length errors
  initial begin
    logic        cur_id;
    logic [2:0]  cur_len;
    int          nbeats;
    bit          presenting;
    bit          err_m;
    bit          exp_mv;
    mreq_t       m;
    presenting = 1'b0;
    err_m      = 1'b0;
    cur_id     = 1'b0;
    cur_len    = '0;
    nbeats     = 1;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    mem_resp_last_i  = 1'b0;
    forever begin
      @(negedge clk);
      mem_req_ready_i = ($urandom % 2) == 0;
      if (phase == 0) begin
        mem_resp_valid_i = ($urandom % 4) == 0;
        mem_resp_data_i  = {$urandom, $urandom};
        mem_resp_last_i  = 1'($urandom);
      end else begin
        if (!presenting && ($urandom % 4) != 0) begin
          presenting      = 1'b1;
          mem_resp_data_i = {$urandom, $urandom};
          mem_resp_last_i = (beat_idx == nbeats - 1);
          exp_resp.push_back('{id: cur_id, data: mem_resp_data_i});
        end
        mem_resp_valid_i = presenting;
      end
      #1;
      if (!rst_i) chk("err", 64'(err_o), 64'(err_m));
      #1;
      if (rst_i) begin
        phase      = 0;
        presenting = 1'b0;
        err_m      = 1'b0;
        done       = 0;
        exp_req.delete();
        exp_resp.delete();
      end else if (phase == 0) begin
        chk("mem_resp_ready_stall", 64'(mem_resp_ready_o), 64'd0);
        exp_mv = (exp_req.size() > 0) && !just_acc;
        chk("mem_req_valid", 64'(mem_req_valid_o), 64'(exp_mv));
        if (exp_mv && mem_req_valid_o) begin
          m = exp_req[0];
          chk("mem_req_id", 64'(mem_req_id_o), 64'(m.id));
          chk("mem_req_addr", 64'(mem_req_addr_o), 64'(m.addr));
          chk("mem_req_len", 64'(mem_req_len_o), 64'(m.len));
          if (mem_req_ready_i) begin
            void'(exp_req.pop_front());
            cur_id   = m.id;
            cur_len  = m.len;
            nbeats   = (($urandom % 6) == 0) ? int'($urandom_range(1, 8)) : int'(m.len) + 1;
            beat_idx = 0;
            phase    = 1;
          end
        end
      end else begin
        chk("mem_req_valid_resp", 64'(mem_req_valid_o), 64'd0);
        chk("mem_resp_ready", 64'(mem_resp_ready_o), 64'(resp_ready_i[cur_id]));
        if (presenting && mem_resp_ready_o) begin
          if (mem_resp_last_i != ((beat_idx % 8) == int'(cur_len))) err_m = 1'b1;
          beat_idx++;
          presenting = 1'b0;
          if (mem_resp_last_i) begin
            phase = 0;
            done++;
          end
        end
      end
    end
  end

  // response monitor: every routed beat must match the next expected beat
  initial begin
    logic [1:0] ev;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i) begin
        ev = 2'b00;
        if (exp_resp.size() > 0 && mem_resp_valid_i) ev[exp_resp[0].id] = 1'b1;
        chk("resp_valid", 64'(resp_valid_o), 64'(ev));
        if (ev != 2'b00) begin
          chk("resp_data", resp_data_o, exp_resp[0].data);
          if (resp_ready_i[exp_resp[0].id]) void'(exp_resp.pop_front());
        end
      end
    end
  end

  // reset sequencing, mid-burst resets, drain and summary
  initial begin
    int waited;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr_o), 64'd0);
    chk("rst_mem_req_len", 64'(mem_req_len_o), 64'd0);
    chk("rst_mem_req_id", 64'(mem_req_id_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (700) @(negedge clk);
      waited = 0;
      while (!(phase == 1 && beat_idx >= 1) && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 3000) begin
        chk("reach_resp_timeout", 64'(waited), 64'd0);
      end else begin
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("midrst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        chk("midrst_err", 64'(err_o), 64'd0);
        chk("midrst_id", 64'(mem_req_id_o), 64'd0);
      end
    end
    stop = 1'b1;
    waited = 0;
    while (!(pres == 2'b00 && acc == done) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_timeout", 64'(waited >= 5000), 64'd0);
    repeat (4) @(negedge clk);
    chk("grants_made", 64'(grants_seen > 20), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
